decode_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/decode_stage_regfile.sv | 33 +++
 rtl/decode_stage.sv | 156 +++++++++++++++
 tb/tb_decode_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared decode definitions for the issue stage: opcode values (these match
// the ALU's opcode header), instruction field positions, and per-opcode
// operand-usage helpers.
package cpu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_LW  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_LI  = 4'd9;
  localparam logic [3:0] OP_JMP = 4'd10;
  localparam logic [3:0] OP_BEQ = 4'd11;
  localparam logic [3:0] OP_BGT = 4'd12;
  localparam logic [3:0] OP_BLT = 4'd13;

  localparam int OPC_LSB = 28;
  localparam int RD_LSB  = 24;
  localparam int RS1_LSB = 20;
  localparam int RS2_LSB = 16;
  localparam int IMM_LSB = 0;

  // Register-register ALU ops: both sources come from the register file.
  function automatic logic is_rtype(input logic [3:0] op);
    return op <= OP_XOR;
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    return is_rtype(op) || (op == OP_LW) || (op == OP_LI);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'd14) || (op == 4'd15);
  endfunction

  // LI is the only op that ignores rs1.
  function automatic logic uses_rs1(input logic [3:0] op);
    return op != OP_LI;
  endfunction

  function automatic logic uses_rs2(input logic [3:0] op);
    return is_rtype(op) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BGT) || (op == OP_BLT);
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Register file for the issue stage: NREGS x DATAWIDTH, two asynchronous
// read ports, one synchronous write port, synchronous active-high reset.
// R0 always reads zero and ignores writes.
module regfile #(
  parameter int DATAWIDTH = 32,
  parameter int NREGS     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(NREGS)-1:0]     ra1,
  input  logic [$clog2(NREGS)-1:0]     ra2,
  output logic [DATAWIDTH-1:0]         rd1,
  output logic [DATAWIDTH-1:0]         rd2,
  input  logic                         we,
  input  logic [$clog2(NREGS)-1:0]     wa,
  input  logic [DATAWIDTH-1:0]         wd
);

  logic [DATAWIDTH-1:0] mem [NREGS];

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

  // Clear on reset, otherwise write any register but R0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Issue stage ahead of the ALU: decodes a 32-bit instruction, reads operands
// from the register file (with same-cycle writeback bypass), blocks RAW
// hazards with a per-register pending scoreboard, and presents a registered
// operand bundle under a valid/ready handshake.
// Optional build macro DECODE_ILLEGAL_TRAP_EN: opcodes 14/15 are swallowed
// and raise a sticky illegal_o instead of being forwarded.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int NREGS     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr_i,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic                 wb_en_i,
  input  logic [3:0]           wb_addr_i,
  input  logic [DATAWIDTH-1:0] wb_data_i,
  output logic [DATAWIDTH-1:0] a_o,
  output logic [DATAWIDTH-1:0] b_o,
  output logic [3:0]           opcode_o,
  output logic [3:0]           rd_o,
  output logic                 wr_en_o,
  output logic [DATAWIDTH-1:0] rs2_data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic                 illegal_o,
`endif
  output logic                 stall_o
);

  function automatic logic [DATAWIDTH-1:0] sext_imm(input logic signed [15:0] v);
    logic signed [DATAWIDTH-1:0] w;
    w = v;
    return w;
  endfunction

  logic [3:0]          op, rd, rs1, rs2;
  logic signed [15:0]  imm16;

  assign op    = instr_i[OPC_LSB +: 4];
  assign rd    = instr_i[RD_LSB  +: 4];
  assign rs1   = instr_i[RS1_LSB +: 4];
  assign rs2   = instr_i[RS2_LSB +: 4];
  assign imm16 = instr_i[IMM_LSB +: 16];

  logic [DATAWIDTH-1:0] rf_rs1, rf_rs2;

  regfile #(.DATAWIDTH(DATAWIDTH), .NREGS(NREGS)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rf_rs1),
    .rd2 (rf_rs2),
    .we  (wb_en_i),
    .wa  (wb_addr_i),
    .wd  (wb_data_i)
  );

  logic [NREGS-1:0]     pending_q, pending_nxt, clr_mask, set_mask, pending_vis;
  logic [DATAWIDTH-1:0] rs1_val, rs2_val, a_dec, b_dec;
  logic                 use1, use2, hazard, accept, fwd, wr_dec, illegal_op;
  logic                 vld_p1;
  logic [DATAWIDTH-1:0] a_p1, b_p1, rs2_p1;
  logic [3:0]           op_p1, rd_p1;
  logic                 wr_p1;

  // Decode, bypass, hazard detection and scoreboard next-state.
  always_comb begin
    clr_mask    = wb_en_i ? (NREGS'(1) << wb_addr_i) : '0;
    pending_vis = pending_q & ~clr_mask;

    rs1_val = (rs1 == 4'd0) ? '0 :
              (wb_en_i && (wb_addr_i == rs1)) ? wb_data_i : rf_rs1;
    rs2_val = (rs2 == 4'd0) ? '0 :
              (wb_en_i && (wb_addr_i == rs2)) ? wb_data_i : rf_rs2;

`ifdef DECODE_ILLEGAL_TRAP_EN
    illegal_op = is_illegal(op);
`else
    illegal_op = 1'b0;
`endif
    use1 = uses_rs1(op) && !illegal_op;
    use2 = uses_rs2(op);

    hazard = (use1 && pending_vis[rs1]) || (use2 && pending_vis[rs2]);

    instr_ready_o = !hazard && (!vld_p1 || ready_i);
    stall_o       = instr_valid_i && hazard;
    accept        = instr_valid_i && instr_ready_o;
    fwd           = accept && !illegal_op;

    wr_dec = writes_rd(op);
    a_dec  = (op == OP_LI) ? '0 : rs1_val;
    b_dec  = is_rtype(op) ? rs2_val : sext_imm(imm16);

    set_mask    = (fwd && wr_dec && (rd != 4'd0)) ? (NREGS'(1) << rd) : '0;
    pending_nxt = pending_vis | set_mask;
    pending_nxt[0] = 1'b0;
  end

  // ---- stage p1: registered operand bundle toward the ALU ----
  // Load on forward; hold while stalled downstream; drop valid once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      rs2_p1 <= '0;
      op_p1  <= '0;
      rd_p1  <= '0;
      wr_p1  <= 1'b0;
    end else if (fwd) begin
      vld_p1 <= 1'b1;
      a_p1   <= a_dec;
      b_p1   <= b_dec;
      rs2_p1 <= rs2_val;
      op_p1  <= op;
      rd_p1  <= rd;
      wr_p1  <= wr_dec;
    end else if (ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  // Scoreboard: writeback clears, accepted writer sets (set wins).
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_nxt;
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky flag for swallowed illegal opcodes.
  always_ff @(posedge clk) begin
    if (rst)                      illegal_q <= 1'b0;
    else if (accept && illegal_op) illegal_q <= 1'b1;
  end

  assign illegal_o = illegal_q;
`endif

  assign valid_o    = vld_p1;
  assign a_o        = a_p1;
  assign b_o        = b_p1;
  assign rs2_data_o = rs2_p1;
  assign opcode_o   = op_p1;
  assign rd_o       = rd_p1;
  assign wr_en_o    = wr_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios with literal expectations,
// then randomized traffic, all checked against a behavioural model.
module tb_decode_stage;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr_i;
  logic          instr_valid_i;
  logic          instr_ready_o;
  logic          wb_en_i;
  logic [3:0]    wb_addr_i;
  logic [W-1:0]  wb_data_i;
  logic [W-1:0]  a_o, b_o, rs2_data_o;
  logic [3:0]    opcode_o, rd_o;
  logic          wr_en_o, valid_o, ready_i, stall_o;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic          illegal_o;
`endif

  decode_stage #(.DATAWIDTH(W), .NREGS(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .wb_en_i       (wb_en_i),
    .wb_addr_i     (wb_addr_i),
    .wb_data_i     (wb_data_i),
    .a_o           (a_o),
    .b_o           (b_o),
    .opcode_o      (opcode_o),
    .rd_o          (rd_o),
    .wr_en_o       (wr_en_o),
    .rs2_data_o    (rs2_data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .illegal_o     (illegal_o),
`endif
    .stall_o       (stall_o)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state: architectural registers, pending flags and the
  // bundle currently presented to the ALU.
  logic [W-1:0] m_reg [16];
  logic         m_pend [16];
  logic         m_vld, m_wr, m_ill;
  logic [W-1:0] m_a, m_b, m_r2;
  logic [3:0]   m_op, m_rd;
  logic         last_ready, last_stall;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    logic [31:0] w;
    w = {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
    return w;
  endfunction

  function automatic logic m_is_ill(input logic [3:0] op);
`ifdef DECODE_ILLEGAL_TRAP_EN
    return op >= 4'd14;
`else
    return 1'b0;
`endif
  endfunction

  // Value an instruction sees for register s this cycle (writeback visible).
  function automatic logic [W-1:0] m_src(input logic [3:0] s);
    if (s == 4'd0) return '0;
    if (wb_en_i && wb_addr_i == s) return wb_data_i;
    return m_reg[s];
  endfunction

  function automatic logic m_busy(input logic [3:0] s);
    return (s != 4'd0) && m_pend[s] && !(wb_en_i && wb_addr_i == s);
  endfunction

  function automatic logic m_hazard();
    logic [3:0] op;
    logic u1, u2;
    op = instr_i[31:28];
    u1 = (op != 4'd9) && !m_is_ill(op);
    u2 = (op <= 4'd6) || (op == 4'd8) || (op == 4'd11) || (op == 4'd12) || (op == 4'd13);
    return (u1 && m_busy(instr_i[23:20])) || (u2 && m_busy(instr_i[19:16]));
  endfunction

  function automatic logic m_ready();
    return !m_hazard() && (!m_vld || ready_i);
  endfunction

  task automatic m_clock();
    logic [3:0]   op, rd;
    logic [15:0]  imm;
    logic         acc, wr_new;
    if (rst) begin
      m_vld = 0; m_wr = 0; m_ill = 0;
      m_a = '0; m_b = '0; m_r2 = '0; m_op = '0; m_rd = '0;
      for (int i = 0; i < 16; i++) begin m_reg[i] = '0; m_pend[i] = 0; end
      return;
    end
    op     = instr_i[31:28];
    rd     = instr_i[27:24];
    imm    = instr_i[15:0];
    acc    = instr_valid_i && m_ready();
    wr_new = (op <= 4'd7) || (op == 4'd9);
    if (acc && !m_is_ill(op)) begin
      m_vld = 1;
      m_op  = op;
      m_rd  = rd;
      m_wr  = wr_new;
      m_a   = (op == 4'd9) ? '0 : m_src(instr_i[23:20]);
      m_b   = (op <= 4'd6) ? m_src(instr_i[19:16]) : {{16{imm[15]}}, imm};
      m_r2  = m_src(instr_i[19:16]);
    end else if (ready_i) begin
      m_vld = 0;
    end
    if (acc && m_is_ill(op)) m_ill = 1;
    if (wb_en_i) begin
      if (wb_addr_i != 0) m_reg[wb_addr_i] = wb_data_i;
      m_pend[wb_addr_i] = 0;
    end
    if (acc && !m_is_ill(op) && wr_new && rd != 0) m_pend[rd] = 1;
  endtask

  // One clock: apply inputs, check handshake outputs, clock, check bundle.
  task automatic step(input logic v, input logic [31:0] ins, input logic we,
                      input logic [3:0] wa, input logic [W-1:0] wd,
                      input logic rdy, input logic r);
    instr_valid_i = v; instr_i = ins; wb_en_i = we; wb_addr_i = wa;
    wb_data_i = wd; ready_i = rdy; rst = r;
    #1;
    last_ready = instr_ready_o;
    last_stall = stall_o;
    chk("instr_ready", W'(instr_ready_o), W'(m_ready()));
    chk("stall", W'(stall_o), W'(v && m_hazard()));
    @(posedge clk);
    m_clock();
    #1;
    chk("valid", W'(valid_o), W'(m_vld));
    if (m_vld) begin
      chk("a", a_o, m_a);
      chk("b", b_o, m_b);
      chk("rs2_data", rs2_data_o, m_r2);
      chk("opcode", W'(opcode_o), W'(m_op));
      chk("rd", W'(rd_o), W'(m_rd));
      chk("wr_en", W'(wr_en_o), W'(m_wr));
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("illegal", W'(illegal_o), W'(m_ill));
`endif
  endtask

  initial begin
    logic [3:0]  wa;
    logic        we;
    int          start;
    instr_valid_i = 0; instr_i = '0; wb_en_i = 0; wb_addr_i = '0;
    wb_data_i = '0; ready_i = 1; rst = 1;
    #2;

    // Reset state
    step(0, '0, 0, 0, 0, 1, 1);
    step(0, '0, 0, 0, 0, 1, 1);
    chk("rst_valid", W'(valid_o), 0);
    chk("rst_a", a_o, 0);
    chk("rst_b", b_o, 0);
    chk("rst_rs2", rs2_data_o, 0);
    chk("rst_op", W'(opcode_o), 0);
    chk("rst_wr", W'(wr_en_o), 0);

    // LI r1,#34 / LI r2,#35 with writebacks
    step(1, enc(9, 1, 0, 0, 34), 0, 0, 0, 1, 0);
    chk("li1_b", b_o, 34);
    chk("li1_op", W'(opcode_o), 9);
    step(0, '0, 1, 1, 34, 1, 0);
    step(1, enc(9, 2, 0, 0, 35), 0, 0, 0, 1, 0);
    step(0, '0, 1, 2, 35, 1, 0);

    // ADD r3,r1,r2
    step(1, enc(0, 3, 1, 2, 0), 0, 0, 0, 1, 0);
    chk("add_valid", W'(valid_o), 1);
    chk("add_a", a_o, 34);
    chk("add_b", b_o, 35);
    chk("add_rd", W'(rd_o), 3);
    chk("add_wr", W'(wr_en_o), 1);

    // LI r4,#-1
    step(1, enc(9, 4, 0, 0, 16'hFFFF), 1, 3, 69, 1, 0);
    chk("li4_a", a_o, 0);
    chk("li4_b", b_o, 32'hFFFF_FFFF);
    chk("li4_op", W'(opcode_o), 9);

    // RAW hazard on r5, resolved by same-cycle writeback bypass
    step(1, enc(0, 5, 1, 2, 0), 1, 4, 32'hFFFF_FFFF, 1, 0);
    step(1, enc(1, 6, 5, 1, 0), 0, 0, 0, 1, 0);
    chk("raw_ready", W'(last_ready), 0);
    chk("raw_stall", W'(last_stall), 1);
    step(1, enc(1, 6, 5, 1, 0), 0, 0, 0, 1, 0);
    chk("raw_stall2", W'(last_stall), 1);
    step(1, enc(1, 6, 5, 1, 0), 1, 5, 69, 1, 0);
    chk("byp_ready", W'(last_ready), 1);
    chk("byp_a", a_o, 69);
    chk("byp_op", W'(opcode_o), 1);

    // Backpressure for three cycles, then back-to-back issue
    for (int k = 0; k < 3; k++) begin
      step(1, enc(0, 7, 1, 2, 0), 0, 0, 0, 0, 0);
      chk("bp_ready", W'(last_ready), 0);
      chk("bp_hold_a", a_o, 69);
    end
    step(1, enc(0, 7, 1, 2, 0), 0, 0, 0, 1, 0);
    chk("bp_issue_a", a_o, 34);
    step(1, enc(0, 8, 2, 1, 0), 0, 0, 0, 1, 0);
    chk("b2b_ready", W'(last_ready), 1);
    chk("b2b_a", a_o, 35);

    // SW r1,8(r2): no pending set on r1
    step(1, enc(8, 1, 2, 1, 8), 0, 0, 0, 1, 0);
    chk("sw_a", a_o, 35);
    chk("sw_b", b_o, 8);
    chk("sw_rs2", rs2_data_o, 34);
    chk("sw_wr", W'(wr_en_o), 0);
    step(1, enc(0, 9, 1, 1, 0), 0, 0, 0, 1, 0);
    chk("sw_nostall", W'(last_ready), 1);

    // Reset during a stall on pending r5
    step(1, enc(9, 5, 0, 0, 1), 0, 0, 0, 1, 0);
    step(1, enc(1, 6, 5, 1, 0), 0, 0, 0, 1, 0);
    chk("pre_rst_stall", W'(last_stall), 1);
    step(1, enc(1, 6, 5, 1, 0), 0, 0, 0, 1, 1);
    chk("mid_rst_valid", W'(valid_o), 0);
    step(1, enc(0, 10, 5, 0, 0), 0, 0, 0, 1, 0);
    chk("post_rst_ready", W'(last_ready), 1);
    chk("post_rst_r5", a_o, 0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      we = ($urandom_range(0, 1) == 1);
      wa = 4'($urandom_range(0, 15));
      start = $urandom_range(0, 15);
      for (int k = 0; k < 16; k++) begin
        if (m_pend[(start + k) % 16]) begin
          wa = 4'((start + k) % 16);
          break;
        end
      end
      step($urandom_range(0, 9) < 8,
           enc($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 65535)),
           we, wa, W'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 299) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
